// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and sizing for the sequential restoring divider
package div_pkg;
  localparam int WIDTH_DEF = 16;
  localparam int CNT_W = 5;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/cla16_subtractor.sv
// cla16_subtractor: a - b as a + ~b + 1 using 4-bit lookahead groups and a group carry generator
module cla16_subtractor (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] difference,
  output logic        carry_out
);
  logic [15:0] p, g, c;
  logic [3:0] gg, gp;
  logic [4:0] gc;
  assign p = a ^ ~b;
  assign g = a & ~b;
  for (genvar i = 0; i < 4; i++) begin : g_grp
    logic [3:0] p4, g4;
    assign p4 = p[4*i +: 4];
    assign g4 = g[4*i +: 4];
    assign c[4*i]   = gc[i];
    assign c[4*i+1] = g4[0] | (p4[0] & gc[i]);
    assign c[4*i+2] = g4[1] | (p4[1] & g4[0]) | (&p4[1:0] & gc[i]);
    assign c[4*i+3] = g4[2] | (p4[2] & g4[1]) | (&p4[2:1] & g4[0]) | (&p4[2:0] & gc[i]);
    assign gg[i] = g4[3] | (p4[3] & g4[2]) | (&p4[3:2] & g4[1]) | (&p4[3:1] & g4[0]);
    assign gp[i] = &p4;
  end
  // carry-in of 1 completes the two's-complement negation of b
  assign gc[0] = 1'b1;
  assign gc[1] = gg[0] | gp[0];
  assign gc[2] = gg[1] | (gp[1] & gg[0]) | (&gp[1:0]);
  assign gc[3] = gg[2] | (gp[2] & gg[1]) | (&gp[2:1] & gg[0]) | (&gp[2:0]);
  assign gc[4] = gg[3] | (gp[3] & gg[2]) | (&gp[3:2] & gg[1]) | (&gp[3:1] & gg[0]) | (&gp[3:0]);
  assign difference = p ^ c;
  assign carry_out = gc[4];
endmodule

// File: rtl/seq_restoring_divider16.sv
// seq_restoring_divider16: 16-cycle restoring unsigned divider with divide-by-zero flag
module seq_restoring_divider16
  import div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] d, diff;
  logic [WIDTH:0] t;
  logic cout, ok;
  assign t = {remainder, quotient[WIDTH-1]};
  // a set T[16] means the partial remainder already exceeds any 16-bit divisor
  assign ok = cout | t[WIDTH];
  cla16_subtractor u_sub (
    .a(t[WIDTH-1:0]),
    .b(d),
    .difference(diff),
    .carry_out(cout)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      quotient <= '0;
      remainder <= '0;
      div_by_zero <= 1'b0;
      cnt <= '0;
      d <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            d <= divisor;
            cnt <= '0;
            busy <= 1'b1;
            div_by_zero <= 1'b0;
            state <= (divisor == '0) ? DONE : RUN;
            quotient <= (divisor == '0) ? '1 : dividend;
            remainder <= (divisor == '0) ? dividend : '0;
          end
        end
        RUN: begin
          remainder <= ok ? diff : t[WIDTH-1:0];
          quotient <= {quotient[WIDTH-2:0], ok};
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state <= DONE;
            done <= 1'b1;
          end
        end
        default: begin
          // a zero divisor skips RUN, so its done pulse is issued on the way out
          state <= IDLE;
          busy <= 1'b0;
          done <= (d == '0);
          div_by_zero <= (d == '0);
        end
      endcase
    end
  end
endmodule

// File: tb/tb_seq_restoring_divider16.sv
// tb_seq_restoring_divider16: scoreboard bench for the sequential restoring divider
module tb_seq_restoring_divider16;
  typedef struct packed {
    logic [15:0] q;
    logic [15:0] r;
    logic        z;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [15:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic busy, done, div_by_zero;
  logic [15:0] quotient, remainder;
  int total = 0;
  int bad = 0;
  exp_t sb[$];

  seq_restoring_divider16 dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    e.q = (b == 0) ? 16'hFFFF : a / b;
    e.r = (b == 0) ? a : a % b;
    e.z = (b == 0);
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("sb_quotient", 32'(quotient), 32'(e.q));
        check("sb_remainder", 32'(remainder), 32'(e.r));
        check("sb_dbz", 32'(div_by_zero), 32'(e.z));
      end
    end
  end

  // called at a negedge; the following posedge is the accepting edge
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input bit push);
    dividend = a;
    divisor = b;
    start = 1'b1;
    if (push) sb.push_back(model(a, b));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int base, output int n);
    n = base;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic finish_op(input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    e = model(a, b);
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
    check("hold_q", 32'(quotient), 32'(e.q));
    check("hold_r", 32'(remainder), 32'(e.r));
  endtask

  initial begin
    int n;
    logic [15:0] a, b;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_q", 32'(quotient), 32'd0);
    check("rst_r", 32'(remainder), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(16'd100, 16'd7, 1'b1);
    check("busy_run", 32'(busy), 32'd1);
    wait_done(0, n);
    check("lat_100_7", 32'(n), 32'd16);
    check("q_100_7", 32'(quotient), 32'd14);
    check("r_100_7", 32'(remainder), 32'd2);
    check("busy_done", 32'(busy), 32'd1);
    finish_op(16'd100, 16'd7);

    issue(16'hFFFF, 16'h8000, 1'b1);
    wait_done(0, n);
    check("lat_ffff_8000", 32'(n), 32'd16);
    check("r_ffff_8000", 32'(remainder), 32'h7FFF);
    finish_op(16'hFFFF, 16'h8000);

    issue(16'hFFFF, 16'd1, 1'b1);
    wait_done(0, n);
    check("q_ffff_1", 32'(quotient), 32'hFFFF);
    finish_op(16'hFFFF, 16'd1);

    issue(16'd5, 16'd0, 1'b1);
    wait_done(0, n);
    check("lat_div0", 32'(n), 32'd1);
    check("dbz_div0", 32'(div_by_zero), 32'd1);
    check("r_div0", 32'(remainder), 32'd5);
    finish_op(16'd5, 16'd0);

    issue(16'd100, 16'd7, 1'b1);
    repeat (4) @(negedge clk);
    dividend = 16'd9;
    divisor = 16'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(5, n);
    check("lat_ignore", 32'(n), 32'd16);
    check("q_ignore", 32'(quotient), 32'd14);
    check("r_ignore", 32'(remainder), 32'd2);
    finish_op(16'd100, 16'd7);
    issue(16'd9, 16'd3, 1'b1);
    wait_done(0, n);
    check("lat_b2b", 32'(n), 32'd16);
    check("q_9_3", 32'(quotient), 32'd3);
    finish_op(16'd9, 16'd3);

    issue(16'd1000, 16'd3, 1'b0);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_q", 32'(quotient), 32'd0);
    check("arst_r", 32'(remainder), 32'd0);
    check("arst_dbz", 32'(div_by_zero), 32'd0);
    repeat (20) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(16'd1000, 16'd3, 1'b1);
    wait_done(0, n);
    check("lat_after_rst", 32'(n), 32'd16);
    check("q_1000_3", 32'(quotient), 32'd333);
    check("r_1000_3", 32'(remainder), 32'd1);
    finish_op(16'd1000, 16'd3);

    for (int i = 0; i < 2000; i++) begin
      a = 16'($urandom);
      case ($urandom_range(0, 3))
        0: b = 16'($urandom_range(0, 15));
        1: b = 16'($urandom_range(16'h8000, 16'hFFFF));
        default: b = 16'($urandom);
      endcase
      issue(a, b, 1'b1);
      wait_done(0, n);
      check("lat_rand", 32'(n), (b == 0) ? 32'd1 : 32'd16);
      @(negedge clk);
    end
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
